// File: rtl/mult2x2_behavioral.sv
// Registered unsigned 2x2-bit multiplier with bit-level operand/product ports.
// Latency 1 cycle, or 2 cycles when MULT2X2_PIPE2_EN is defined; one product per cycle.
// No backpressure: every in_valid beat yields exactly one out_valid beat; idle cycles hold the product.
module mult2x2_behavioral (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f3,
    output logic f2,
    output logic f1,
    output logic f0,
    output logic out_valid
);

    logic [3:0] prod_q, prod_d;
    logic       vld_q,  vld_d;

`ifdef MULT2X2_PIPE2_EN
    logic [3:0] pp_q, pp_d;
    logic       v1_q;
    logic       ac, ad, bc, bd;

    assign pp_d = {a & c, a & d, b & c, b & d};

    // Partial products only load on a valid beat so stage 1 stays quiet while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_q <= 4'b0000;
            v1_q <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                pp_q <= pp_d;
            end
        end
    end

    assign {ac, ad, bc, bd} = pp_q;

    always_comb begin
        prod_d = prod_q;
        if (v1_q) begin
            prod_d = {ac & ad & bc, ac ^ (ad & bc), ad ^ bc, bd};
        end
    end

    assign vld_d = v1_q;
`else
    always_comb begin
        prod_d = prod_q;
        if (in_valid) begin
            prod_d = {2'b00, a, b} * {2'b00, c, d};
        end
    end

    assign vld_d = in_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= 4'b0000;
            vld_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
        end
    end

    assign {f3, f2, f1, f0} = prod_q;
    assign out_valid        = vld_q;

endmodule

// File: tb/tb_mult2x2_behavioral.sv
// Randomized and directed bench for mult2x2_behavioral against a queue-based latency model.
module tb_mult2x2_behavioral;

`ifdef MULT2X2_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n, in_valid, a, b, c, d;
    logic f3, f2, f1, f0, out_valid;

    mult2x2_behavioral dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .f3        (f3),
        .f2        (f2),
        .f1        (f1),
        .f0        (f0),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [3:0] p;
    } ent_t;

    ent_t       exp_q[$];
    logic       exp_v;
    logic [3:0] exp_p;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_vld"}, {7'd0, out_valid}, {7'd0, exp_v});
        check({tag, "_prod"}, {4'd0, f3, f2, f1, f0}, {4'd0, exp_p});
    endtask

    // Called just after a negedge: drive, glitch operands mid-cycle, clock, then check at the next negedge.
    task automatic cycle(input string tag, input logic iv, input logic [1:0] opa, input logic [1:0] opb);
        ent_t e;
        in_valid = iv;
        {a, b} = opa;
        {c, d} = opb;
        #1 {a, b, c, d} = 4'($urandom);
        #1 {a, b} = opa; {c, d} = opb;
        @(posedge clk);
        e.v = iv;
        e.p = 4'(int'(opa) * int'(opb));
        exp_q.push_back(e);
        if (exp_q.size() == LAT) begin
            e = exp_q.pop_front();
            exp_v = e.v;
            if (e.v) exp_p = e.p;
        end else begin
            exp_v = 1'b0;
        end
        @(negedge clk);
        check_outs(tag);
    endtask

    // Asynchronous reset pulse inside the low phase; outputs must clear before any edge.
    task automatic reset_pulse(input string tag);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_v = 1'b0;
        exp_p = 4'd0;
        check_outs(tag);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outs({tag, "_post"});
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        {a, b, c, d} = 4'b0000;
        exp_v = 1'b0;
        exp_p = 4'd0;
        #1 check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive sweep, then drain.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            cycle("exh", 1'b1, v[3:2], v[1:0]);
        end
        repeat (LAT) cycle("drain", 1'b0, 2'd0, 2'd0);

        // Async reset while the product is 9.
        cycle("nine", 1'b1, 2'd3, 2'd3);
        repeat (LAT - 1) cycle("nine_w", 1'b0, 2'd3, 2'd3);
        check("nine_val", {4'd0, f3, f2, f1, f0}, 8'd9);
        reset_pulse("rst9");

        // Hold: capture 3*2 then idle with all-ones operands.
        cycle("hold_cap", 1'b1, 2'd3, 2'd2);
        repeat (LAT + 2) cycle("hold", 1'b0, 2'd3, 2'd3);
        check("hold_val", {4'd0, f3, f2, f1, f0}, 8'd6);

        // Back-to-back.
        cycle("b2b", 1'b1, 2'd1, 2'd1);
        cycle("b2b", 1'b1, 2'd2, 2'd2);
        cycle("b2b", 1'b1, 2'd3, 2'd3);
        repeat (LAT) cycle("b2b_dr", 1'b0, 2'd0, 2'd0);

        // Single-beat pulse; model checks position and width of out_valid.
        cycle("pulse", 1'b1, 2'd2, 2'd3);
        repeat (3) cycle("pulse_w", 1'b0, 2'd1, 2'd1);

        // Reset with a product in flight: nothing may emerge afterwards.
        cycle("inflt", 1'b1, 2'd3, 2'd3);
        reset_pulse("rst_fl");
        repeat (3) cycle("inflt_w", 1'b0, 2'd3, 2'd3);
        check("inflt_val", {4'd0, f3, f2, f1, f0}, 8'd0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle("rnd", 1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
